// File: rtl/demux_1x4_nbit_buf_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the buffered 1-to-4 demultiplexer.
//
//   NUM_LANES   : number of output lanes fed by the demux.
//   lane_sel_t  : 2-bit lane index, used for the external select, the
//                 round-robin pointer and the resolved lane select.
//   lane_onehot : expands a lane index into a one-hot lane mask.
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  // One-hot lane mask for a lane index; bit k set <=> lane k addressed.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_sel_t lane);
    logic [NUM_LANES-1:0] mask;
    mask = '0;
    mask[lane] = 1'b1;
    return mask;
  endfunction

endpackage : demux_pkg

// File: rtl/demux_1x4_nbit_buf_lane_buf.sv
// -----------------------------------------------------------------------------
// lane_buf_nbit
//   One-entry holding register for a single output lane of the demux.
//
//   clk        : system clock, state updates on the rising edge.
//   reset_n    : asynchronous active-low reset; empties the lane, clears data.
//   fill       : load fill_data this cycle (only raised when the lane can
//                take a word, i.e. it is empty or draining this cycle).
//   fill_data  : word to load.
//   out_ready  : consumer takes the held word this cycle.
//   valid      : lane holds an undelivered word.
//   data       : held word; keeps its last value after being drained.
// -----------------------------------------------------------------------------
module lane_buf_nbit #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         fill,
  input  logic [N-1:0] fill_data,
  input  logic         out_ready,
  output logic         valid,
  output logic [N-1:0] data
);

  logic         valid_q;
  logic         valid_d;
  logic [N-1:0] data_q;
  logic [N-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (fill) begin
      // A fill wins over a simultaneous drain, so the lane stays valid and
      // sustains one word per cycle behind an always-ready consumer.
      valid_d = 1'b1;
      data_d  = fill_data;
    end else if (valid_q && out_ready) begin
      // Drain leaves the data register untouched on purpose.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule : lane_buf_nbit

// File: rtl/demux_1x4_nbit_buf.sv
// -----------------------------------------------------------------------------
// demux_1x4_nbit_buf
//   Buffered 1-to-4 demultiplexer. One N-bit valid/ready input stream is
//   steered, word by word, into one of four one-entry lane buffers, each with
//   its own valid/ready handshake toward an independent consumer.
//
//   Parameters
//     N           : data width of the input and every lane.
//     ROUND_ROBIN : 0 -> lane chosen by s; 1 -> lane chosen by ptr.
//
//   Ports
//     clk                  : system clock.
//     reset_n              : asynchronous active-low reset.
//     in_data/in_valid     : producer word and its valid.
//     in_ready             : block accepts in_data this cycle.
//     s                    : external lane select (used when ROUND_ROBIN=0).
//     out_data0..3         : lane holding-register contents.
//     out_valid[k]         : lane k holds an undelivered word.
//     out_ready[k]         : consumer k takes lane k's word this cycle.
//     ptr                  : accept counter mod 4; the lane select when
//                            ROUND_ROBIN=1.
// -----------------------------------------------------------------------------
module demux_1x4_nbit_buf
  import demux_pkg::*;
#(
  parameter int N           = 3,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  lane_sel_t            s,
  output logic [N-1:0]         out_data0,
  output logic [N-1:0]         out_data1,
  output logic [N-1:0]         out_data2,
  output logic [N-1:0]         out_data3,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output lane_sel_t            ptr
);

  lane_sel_t            sel;
  lane_sel_t            ptr_q;
  lane_sel_t            ptr_d;
  logic                 accept;
  logic [NUM_LANES-1:0] fill;
  logic [N-1:0]         lane_data [NUM_LANES];

  // Resolved lane for this cycle.
  always_comb begin
    if (ROUND_ROBIN != 0) begin
      sel = ptr_q;
    end else begin
      sel = s;
    end
  end

  // Ready is a combinational pass-through of the selected consumer's ready,
  // so a full lane whose consumer is taking its word can be refilled in the
  // same cycle. Gated by reset_n so nothing is accepted while in reset.
  assign in_ready = reset_n & (~out_valid[sel] | out_ready[sel]);
  assign accept   = in_valid & in_ready;
  assign fill     = accept ? lane_onehot(sel) : '0;

  // ptr counts accepts mod 4 regardless of the selection mode.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = lane_sel_t'(ptr_q + 2'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_buf_nbit #(
      .N (N)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .fill      (fill[gi]),
      .fill_data (in_data),
      .out_ready (out_ready[gi]),
      .valid     (out_valid[gi]),
      .data      (lane_data[gi])
    );
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];

endmodule : demux_1x4_nbit_buf

// File: tb/tb_demux_1x4_nbit_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_1x4_nbit_buf
//   Directed bench for the buffered 1-to-4 demux. Instance a uses the external
//   select, instance b uses round-robin selection. Expected lane words are
//   pushed to a scoreboard when driven and popped when they appear on a lane.
// -----------------------------------------------------------------------------
module tb_demux_1x4_nbit_buf;

  logic       clk = 1'b0;
  logic       reset_n;

  // Instance a: ROUND_ROBIN = 0
  logic [2:0] in_data_a;
  logic       in_valid_a;
  logic       in_ready_a;
  logic [1:0] s_a;
  logic [2:0] od_a0, od_a1, od_a2, od_a3;
  logic [3:0] out_valid_a;
  logic [3:0] out_ready_a;
  logic [1:0] ptr_a;

  // Instance b: ROUND_ROBIN = 1
  logic [2:0] in_data_b;
  logic       in_valid_b;
  logic       in_ready_b;
  logic [1:0] s_b;
  logic [2:0] od_b0, od_b1, od_b2, od_b3;
  logic [3:0] out_valid_b;
  logic [3:0] out_ready_b;
  logic [1:0] ptr_b;

  int n_eval = 0;
  int n_fail = 0;

  typedef struct {
    int         lane;
    logic [2:0] data;
    string      tag;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  demux_1x4_nbit_buf #(.N(3), .ROUND_ROBIN(0)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .s         (s_a),
    .out_data0 (od_a0),
    .out_data1 (od_a1),
    .out_data2 (od_a2),
    .out_data3 (od_a3),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .ptr       (ptr_a)
  );

  demux_1x4_nbit_buf #(.N(3), .ROUND_ROBIN(1)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .s         (s_b),
    .out_data0 (od_b0),
    .out_data1 (od_b1),
    .out_data2 (od_b2),
    .out_data3 (od_b3),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .ptr       (ptr_b)
  );

  function automatic logic [2:0] lane_a(input int k);
    case (k)
      0:       return od_a0;
      1:       return od_a1;
      2:       return od_a2;
      default: return od_a3;
    endcase
  endfunction

  function automatic logic [2:0] lane_b(input int k);
    case (k)
      0:       return od_b0;
      1:       return od_b1;
      2:       return od_b2;
      default: return od_b3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_a();
    exp_t e;
    if (sb_a.size() == 0) begin
      chk("sb_a_empty", 32'd1, 32'd0);
    end else begin
      e = sb_a.pop_front();
      chk(e.tag, {29'd0, lane_a(e.lane)}, {29'd0, e.data});
    end
  endtask

  task automatic pop_b();
    exp_t e;
    if (sb_b.size() == 0) begin
      chk("sb_b_empty", 32'd1, 32'd0);
    end else begin
      e = sb_b.pop_front();
      chk(e.tag, {29'd0, lane_b(e.lane)}, {29'd0, e.data});
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    in_data_a   = '0;
    in_valid_a  = 1'b0;
    s_a         = '0;
    out_ready_a = '0;
    in_data_b   = '0;
    in_valid_b  = 1'b0;
    s_b         = '0;
    out_ready_b = '0;

    // Reset state
    #3;
    chk("rst_valid_a", {28'd0, out_valid_a}, 32'h0);
    chk("rst_ptr_a",   {30'd0, ptr_a},       32'h0);
    chk("rst_ready_a", {31'd0, in_ready_a},  32'h0);
    chk("rst_valid_b", {28'd0, out_valid_b}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    $display("reset released");

    // Directed select: 5 -> lane 2, 3 -> lane 0
    in_valid_a = 1'b1; s_a = 2'd2; in_data_a = 3'b101;
    #1;
    chk("dir_ready_l2", {31'd0, in_ready_a}, 32'h1);
    sb_a.push_back('{2, 3'b101, "dir_data2"});
    tick();
    s_a = 2'd0; in_data_a = 3'b011;
    sb_a.push_back('{0, 3'b011, "dir_data0"});
    tick();
    in_valid_a = 1'b0;
    chk("dir_valid", {28'd0, out_valid_a}, 32'h5);
    pop_a();
    pop_a();
    $display("directed: out_valid=%b d2=%b d0=%b", out_valid_a, od_a2, od_a0);

    // Lane 2 full and stalled: no accept until out_ready[2]
    in_valid_a = 1'b1; s_a = 2'd2; in_data_a = 3'b111;
    #1;
    chk("stall_ready_l2", {31'd0, in_ready_a}, 32'h0);
    tick();
    chk("stall_hold_d2", {29'd0, od_a2}, 32'h5);
    out_ready_a = 4'b0100;
    #1;
    chk("passthru_ready_l2", {31'd0, in_ready_a}, 32'h1);
    sb_a.push_back('{2, 3'b111, "refill_data2"});
    tick();
    in_valid_a = 1'b0; out_ready_a = 4'b0000;
    chk("refill_valid", {28'd0, out_valid_a}, 32'h5);
    pop_a();
    chk("ptr_after3", {30'd0, ptr_a}, 32'h3);
    $display("lane2 refill: d2=%b ptr=%0d", od_a2, ptr_a);

    // Backpressure hold on lane 1
    in_valid_a = 1'b1; s_a = 2'd1; in_data_a = 3'b110;
    sb_a.push_back('{1, 3'b110, "bp_fill_d1"});
    tick();
    pop_a();
    in_data_a = 3'b001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), {31'd0, in_ready_a}, 32'h0);
      chk($sformatf("bp_hold_%0d", i), {29'd0, od_a1}, 32'h6);
      tick();
    end
    out_ready_a = 4'b0010;
    #1;
    chk("bp_release_ready", {31'd0, in_ready_a}, 32'h1);
    sb_a.push_back('{1, 3'b001, "bp_new_d1"});
    tick();
    in_valid_a = 1'b0; out_ready_a = 4'b0000;
    pop_a();
    chk("bp_valid", {28'd0, out_valid_a}, 32'h7);
    chk("ptr_after5", {30'd0, ptr_a}, 32'h1);
    $display("backpressure: d1=%b out_valid=%b", od_a1, out_valid_a);

    // Same-lane drain + fill on lane 3
    in_valid_a = 1'b1; s_a = 2'd3; in_data_a = 3'b010;
    sb_a.push_back('{3, 3'b010, "df_first_d3"});
    tick();
    pop_a();
    chk("df_full", {28'd0, out_valid_a}, 32'hf);
    out_ready_a = 4'b1000; in_data_a = 3'b111;
    #1;
    chk("df_ready", {31'd0, in_ready_a}, 32'h1);
    sb_a.push_back('{3, 3'b111, "df_new_d3"});
    tick();
    in_valid_a = 1'b0; out_ready_a = 4'b0000;
    chk("df_valid_stays", {28'd0, out_valid_a}, 32'hf);
    pop_a();
    chk("ptr_after7", {30'd0, ptr_a}, 32'h3);
    $display("drain+fill: d3=%b out_valid=%b", od_a3, out_valid_a);

    // Parallel drain of all four lanes
    out_ready_a = 4'b1111;
    tick();
    out_ready_a = 4'b0000;
    chk("pd_valid", {28'd0, out_valid_a}, 32'h0);
    chk("pd_d0", {29'd0, od_a0}, 32'h3);
    chk("pd_d1", {29'd0, od_a1}, 32'h1);
    chk("pd_d2", {29'd0, od_a2}, 32'h7);
    chk("pd_d3", {29'd0, od_a3}, 32'h7);
    $display("parallel drain: out_valid=%b", out_valid_a);

    // Refill all lanes of instance a for the mid-operation reset
    in_valid_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_a = 2'(k); in_data_a = 3'(k + 4);
      sb_a.push_back('{k, 3'(k + 4), $sformatf("refill_all_%0d", k)});
      tick();
    end
    in_valid_a = 1'b0;
    chk("refill_all_valid", {28'd0, out_valid_a}, 32'hf);
    for (int k = 0; k < 4; k++) pop_a();
    chk("ptr_after11", {30'd0, ptr_a}, 32'h3);

    // Round-robin stream 1..6 with all consumers ready; s_b is ignored
    out_ready_b = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_valid_b = 1'b1; in_data_b = 3'(i + 1); s_b = 2'(3 - (i % 4));
      #1;
      chk($sformatf("rr_ptr_%0d", i), {30'd0, ptr_b}, 32'(i % 4));
      chk($sformatf("rr_ready_%0d", i), {31'd0, in_ready_b}, 32'h1);
      sb_b.push_back('{i % 4, 3'(i + 1), $sformatf("rr_data_%0d", i)});
      tick();
      chk($sformatf("rr_valid_%0d", i), {28'd0, out_valid_b}, 32'(1 << (i % 4)));
      pop_b();
      $display("rr word %0d -> lane %0d ptr=%0d", i + 1, i % 4, ptr_b);
    end
    in_valid_b = 1'b0;
    chk("rr_ptr_end", {30'd0, ptr_b}, 32'h2);

    // Asynchronous reset mid-cycle with instance a full
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_valid_a", {28'd0, out_valid_a}, 32'h0);
    chk("mrst_ptr_a",   {30'd0, ptr_a},       32'h0);
    chk("mrst_ready_a", {31'd0, in_ready_a},  32'h0);
    chk("mrst_data_a",  {20'd0, od_a3, od_a2, od_a1, od_a0}, 32'h0);
    chk("mrst_ptr_b",   {30'd0, ptr_b},       32'h0);
    chk("mrst_data_b",  {20'd0, od_b3, od_b2, od_b1, od_b0}, 32'h0);
    chk("mrst_ready_b", {31'd0, in_ready_b},  32'h0);
    $display("mid-operation reset: out_valid_a=%b ptr_a=%0d", out_valid_a, ptr_a);
    tick();
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule : tb_demux_1x4_nbit_buf
